ula_registro_saida: RTL and testbench
=====================================

Name: ula_registro_saida

Overview:
Output stage of the 4-bit ULA, directly downstream of the 8:1 4-bit result multiplexer. It captures the selected result Y, the opcode S that selected it, and the adder carry/overflow into a small FIFO with valid/ready handshakes. It derives the Z/N/C/V flags per entry and presents result and flags to the consumer, such as a register file or display driver. This decouples the combinational ULA from a consumer that may stall.

Parameters:
WIDTH  4  result width in bits (matches the mux data width)
DEPTH  2  FIFO entries (power of two, >= 2)

Ports:
clk        input   1      rising-edge clock
rst_n      input   1      asynchronous active-low reset
flush      input   1      synchronous discard of all stored entries
in_valid   input   1      upstream result valid
in_ready   output  1      stage can accept an entry
RESULT     input   WIDTH  mux output Y
OP         input   3      mux select S for this result
CARRY_IN   input   1      adder carry-out (stored as C)
OVF_IN     input   1      adder signed overflow (stored as V)
out_valid  output  1      head entry valid
out_ready  input   1      consumer accepts head
OUT_Y      output  WIDTH  head result
OUT_OP     output  3      head opcode
FLAG_Z     output  1      head result == 0
FLAG_N     output  1      head result MSB
FLAG_C     output  1      head stored carry
FLAG_V     output  1      head stored overflow

Behaviour:
- Reset (rst_n low, asynchronous): count=0, read and write pointers 0, out_valid=0, OUT_Y/OUT_OP/flags=0. Storage contents are don't-care but outputs are masked to 0 while empty.
- in_ready = (count != DEPTH). It is a registered-state function only and has no combinational path from out_ready.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- On push: store {RESULT, OP, Z=(RESULT==0), N=RESULT[WIDTH-1], C=CARRY_IN, V=OVF_IN} at wr_ptr. Flags are computed at capture, not at output.
- Latency: a push into an empty FIFO gives out_valid=1 with that data on the next rising edge. There is no combinational bypass.
- out_valid = (count != 0). Outputs always show the entry at rd_ptr and are zeroed when empty.
- Push and pop in the same cycle: count is unchanged and both pointers advance. Legal only when 0<count<DEPTH, because a full FIFO blocks push and an empty FIFO blocks pop.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- flush (synchronous) has highest priority. It sets count=0 and both pointers to 0, and any push or pop in that cycle is ignored. out_valid=0 on the next cycle.
- rst_n asserted mid-transfer: all entries are lost immediately and outputs go to the reset values asynchronously.
- Output data is stable while out_valid=1 and out_ready=0.
- A pop with no push on the cycle the FIFO holds one entry results in out_valid=0 on the next cycle.

Optional Feature:
ULA_FLAGS_STICKY_EN
- Defined: adds output STICKY_V (1 bit) and input sticky_clr (1 bit).
  - STICKY_V is set on any pop whose FLAG_V=1 and holds until sticky_clr=1.
  - If set and clear occur in the same cycle, set wins.
  - Reset value 0. flush does not clear it.
- Not defined: the ports and logic are absent and the block behaves exactly as above.

Test Plan:
- Reset check: hold rst_n=0, then release → out_valid=0, in_ready=1, all flags 0, OUT_Y=0.
- Single transfer: RESULT=4'h0, OP=3'd2, CARRY_IN=1, OVF_IN=0, in_valid for 1 cycle, out_ready=1 → next cycle out_valid=1, OUT_Y=0, OUT_OP=2, Z=1, N=0, C=1, V=0. The cycle after, out_valid=0.
- Fill and stall: out_ready=0, push 4'h9 then 4'h3 → in_ready=0 after the second push and the third in_valid is not accepted. Raise out_ready → 4'h9 (N=1) then 4'h3 (N=0) in order, and in_ready returns to 1.
- Concurrent push and pop at count=1: stream 4'h1, 4'h2, 4'h3, 4'h4 back-to-back with out_ready=1 → outputs appear in order at one per cycle, count stays 1, pointers wrap correctly.
- Flush: with 2 entries held, assert flush together with in_valid=1 → next cycle out_valid=0, count=0, and the pushed value is discarded.
- Sticky (ULA_FLAGS_STICKY_EN defined): pop an entry with OVF_IN=1, then pop one with OVF_IN=0 → STICKY_V stays 1. Pulse sticky_clr → STICKY_V=0 next cycle.

Source files
------------

// File: rtl/ula_registro_saida_if.sv
// Handshake and data bundle between the ULA mux, its output FIFO stage and the consumer.
// Both sides use valid/ready: a beat transfers on a rising edge where valid and ready are both high.
interface ula_registro_saida_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] RESULT;
    logic [2:0]       OP;
    logic             CARRY_IN;
    logic             OVF_IN;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] OUT_Y;
    logic [2:0]       OUT_OP;
    logic             FLAG_Z;
    logic             FLAG_N;
    logic             FLAG_C;
    logic             FLAG_V;

    modport master (
        output in_valid, RESULT, OP, CARRY_IN, OVF_IN, out_ready,
        input  in_ready, out_valid, OUT_Y, OUT_OP, FLAG_Z, FLAG_N, FLAG_C, FLAG_V
    );

    modport slave (
        input  in_valid, RESULT, OP, CARRY_IN, OVF_IN, out_ready,
        output in_ready, out_valid, OUT_Y, OUT_OP, FLAG_Z, FLAG_N, FLAG_C, FLAG_V
    );
endinterface

// File: rtl/ula_registro_saida.sv
// ULA output stage: small FIFO capturing result, opcode and Z/N/C/V flags.
// Optional ULA_FLAGS_STICKY_EN adds a sticky overflow indicator (STICKY_V, cleared by sticky_clr).
module ula_registro_saida #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
`ifdef ULA_FLAGS_STICKY_EN
    input  logic sticky_clr,
    output logic STICKY_V,
`endif
    ula_registro_saida_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_y   [DEPTH];
    logic [2:0]       mem_op  [DEPTH];
    logic [3:0]       mem_flg [DEPTH];  // {Z, N, C, V}

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic [3:0]    head_flg;

    assign bus.in_ready  = (count != DEPTH[AW:0]);
    assign bus.out_valid = (count != '0);
    assign push = bus.in_valid & bus.in_ready & ~flush;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_y[wr_ptr]   <= bus.RESULT;
            mem_op[wr_ptr]  <= bus.OP;
            mem_flg[wr_ptr] <= {(bus.RESULT == '0), bus.RESULT[WIDTH-1], bus.CARRY_IN, bus.OVF_IN};
        end
    end

    assign head_flg   = bus.out_valid ? mem_flg[rd_ptr] : 4'b0000;
    assign bus.OUT_Y  = bus.out_valid ? mem_y[rd_ptr]  : '0;
    assign bus.OUT_OP = bus.out_valid ? mem_op[rd_ptr] : 3'd0;
    assign bus.FLAG_Z = head_flg[3];
    assign bus.FLAG_N = head_flg[2];
    assign bus.FLAG_C = head_flg[1];
    assign bus.FLAG_V = head_flg[0];

`ifdef ULA_FLAGS_STICKY_EN
    // Set takes priority over clear; flush leaves the indicator alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   STICKY_V <= 1'b0;
        else if (pop && head_flg[0])  STICKY_V <= 1'b1;
        else if (sticky_clr)          STICKY_V <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_ula_registro_saida.sv
// Directed bench for ula_registro_saida: reset, transfer, fill/stall, streaming, flush, async reset.
module tb_ula_registro_saida;
    logic clk;
    logic rst_n;
    logic flush;
`ifdef ULA_FLAGS_STICKY_EN
    logic sticky_clr;
    logic sticky_v;
`endif
    int tests;
    int fails;
    logic [3:0] exp_q[$];
    logic [3:0] exp_v;

    ula_registro_saida_if #(.WIDTH(4)) bus ();

    ula_registro_saida #(.WIDTH(4), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
`ifdef ULA_FLAGS_STICKY_EN
        .sticky_clr (sticky_clr),
        .STICKY_V   (sticky_v),
`endif
        .bus        (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] y, input logic [2:0] op,
                         input logic c, input logic o);
        bus.in_valid = v;
        bus.RESULT   = y;
        bus.OP       = op;
        bus.CARRY_IN = c;
        bus.OVF_IN   = o;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus.FLAG_Z, bus.FLAG_N, bus.FLAG_C, bus.FLAG_V};
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
`ifdef ULA_FLAGS_STICKY_EN
        sticky_clr = 1'b0;
`endif
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // reset state
        chk("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("rst_in_ready",  {7'd0, bus.in_ready},  8'd1);
        chk("rst_out_y",     {4'd0, bus.OUT_Y},     8'd0);
        chk("rst_out_op",    {5'd0, bus.OUT_OP},    8'd0);
        chk("rst_flags",     {4'd0, flags()},       8'd0);
`ifdef ULA_FLAGS_STICKY_EN
        chk("rst_sticky",    {7'd0, sticky_v},      8'd0);
`endif

        // single transfer: zero result with carry
        bus.out_ready = 1'b1;
        drive(1'b1, 4'h0, 3'd2, 1'b1, 1'b0);
        step();
        drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
        chk("single_valid", {7'd0, bus.out_valid}, 8'd1);
        chk("single_y",     {4'd0, bus.OUT_Y},     8'h0);
        chk("single_op",    {5'd0, bus.OUT_OP},    8'd2);
        chk("single_flags", {4'd0, flags()},       8'b1010);
        step();
        chk("single_drain", {7'd0, bus.out_valid}, 8'd0);

        // fill and stall
        bus.out_ready = 1'b0;
        drive(1'b1, 4'h9, 3'd1, 1'b0, 1'b1);
        step();
        chk("fill1_ready", {7'd0, bus.in_ready}, 8'd1);
        chk("fill1_y",     {4'd0, bus.OUT_Y},    8'h9);
        drive(1'b1, 4'h3, 3'd5, 1'b1, 1'b0);
        step();
        chk("fill2_ready", {7'd0, bus.in_ready}, 8'd0);
        drive(1'b1, 4'h7, 3'd6, 1'b0, 1'b0);
        step();
        chk("full_ready",  {7'd0, bus.in_ready}, 8'd0);
        chk("stall_y",     {4'd0, bus.OUT_Y},    8'h9);
        chk("stall_op",    {5'd0, bus.OUT_OP},   8'd1);
        chk("stall_flags", {4'd0, flags()},      8'b0101);
        drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        chk("drain_y",     {4'd0, bus.OUT_Y},    8'h3);
        chk("drain_op",    {5'd0, bus.OUT_OP},   8'd5);
        chk("drain_flags", {4'd0, flags()},      8'b0010);
        chk("drain_ready", {7'd0, bus.in_ready}, 8'd1);
        step();
        chk("drain_empty", {7'd0, bus.out_valid}, 8'd0);

        // back-to-back streaming at count=1, pointers wrap twice
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'(i), 3'(i), 1'b0, 1'b0);
            exp_q.push_back(4'(i));
            step();
            exp_v = exp_q.pop_front();
            chk("stream_y",     {4'd0, bus.OUT_Y},     {4'd0, exp_v});
            chk("stream_valid", {7'd0, bus.out_valid}, 8'd1);
            chk("stream_ready", {7'd0, bus.in_ready},  8'd1);
        end
        drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
        step();
        chk("stream_end", {7'd0, bus.out_valid}, 8'd0);

        // flush with two entries held and a push attempt
        bus.out_ready = 1'b0;
        drive(1'b1, 4'hA, 3'd3, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'hB, 3'd4, 1'b0, 1'b0);
        step();
        chk("pre_flush_ready", {7'd0, bus.in_ready}, 8'd0);
        flush = 1'b1;
        drive(1'b1, 4'hF, 3'd7, 1'b0, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
        chk("flush2_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("flush2_ready", {7'd0, bus.in_ready},  8'd1);
        chk("flush2_y",     {4'd0, bus.OUT_Y},     8'd0);

        // flush at count=1 where the push would otherwise be accepted
        drive(1'b1, 4'h5, 3'd2, 1'b0, 1'b0);
        step();
        flush = 1'b1;
        drive(1'b1, 4'h6, 3'd2, 1'b0, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
        chk("flush1_valid", {7'd0, bus.out_valid}, 8'd0);
        step();
        chk("flush1_discard", {7'd0, bus.out_valid}, 8'd0);

        // asynchronous reset mid-transfer
        drive(1'b1, 4'hC, 3'd1, 1'b1, 1'b1);
        step();
        drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
        chk("pre_arst_valid", {7'd0, bus.out_valid}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("arst_y",     {4'd0, bus.OUT_Y},     8'd0);
        chk("arst_flags", {4'd0, flags()},       8'd0);
        step();
        rst_n = 1'b1;
        step();

`ifdef ULA_FLAGS_STICKY_EN
        // sticky overflow: set on pop with V=1, held through a V=0 pop, cleared by sticky_clr
        bus.out_ready = 1'b1;
        drive(1'b1, 4'h8, 3'd0, 1'b0, 1'b1);
        step();
        drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
        chk("sticky_before_pop", {7'd0, sticky_v}, 8'd0);
        step();
        chk("sticky_set", {7'd0, sticky_v}, 8'd1);
        drive(1'b1, 4'h2, 3'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
        step();
        chk("sticky_hold", {7'd0, sticky_v}, 8'd1);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        chk("sticky_clr", {7'd0, sticky_v}, 8'd0);
`endif

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
